// File: rtl/decode_fetch_queue_pkg.sv
// Shared definitions for the decode fetch queue: MIPS branch-group
// opcode/funct/rt codes, the per-entry tag layout and the entry width helper.
package decode_fetch_queue_pkg;

  // Primary opcodes (instr[31:26]) that belong to the branch group
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  // SPECIAL funct codes (instr[5:0]) for register jumps
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  // REGIMM rt codes (instr[20:16]) for the conditional branches
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  // Sideband bits stored above {instr, pc} in every queue entry
  typedef struct packed {
    logic is_branch;
    logic inst_invalid;
    logic inst_illegal;
    logic inst_miss;
  } fq_tag_t;

  // Entry width: PC + instruction + the four tag bits
  function automatic int fq_entry_w(input int pc_w, input int instr_w);
    return pc_w + instr_w + $bits(fq_tag_t);
  endfunction

endpackage

// File: rtl/decode_fetch_queue_instr_predecode.sv
// Combinational branch predecoder: flags any instruction that has a delay
// slot (conditional branches, j/jal, jr/jalr). Shared with fetch prediction.
module instr_predecode
  import decode_fetch_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_branch
);

  logic [5:0] op;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign rt            = instr[20:16];
  assign funct         = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  // Classify the instruction by opcode, then by rt/funct for the sub-groups
  always_comb begin
    // NOTE: default first so every path assigns is_branch and no latch is inferred.
    is_branch = 1'b0;
    case (op)
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
        is_branch = 1'b1;
      OP_REGIMM:
        is_branch = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                    (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
      OP_SPECIAL:
        is_branch = (funct == FN_JR) || (funct == FN_JALR);
      default:
        is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_fetch_queue.sv
// Instruction queue between fetch and decode. Circular buffer with a separate
// occupancy counter, delay-slot tagging of the head, and two flush modes:
// exception flush (drop all) and branch redirect (keep only the delay slot).
module decode_fetch_queue
  import decode_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic               f_valid,
  output logic               f_ready,
  input  logic [PC_W-1:0]    f_pc,
  input  logic [INSTR_W-1:0] f_instr,
  input  logic               f_inst_miss,
  input  logic               f_inst_illegal,
  input  logic               f_inst_invalid,
  output logic               d_valid,
  input  logic               d_accept,
  output logic [PC_W-1:0]    d_pc,
  output logic [INSTR_W-1:0] d_instr,
  output logic               d_inst_miss,
  output logic               d_inst_illegal,
  output logic               d_inst_invalid,
  output logic               d_in_delayslot,
  input  logic               exp_flush,
  input  logic               redirect_flush,
  output logic [CNT_W-1:0]   q_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = fq_entry_w(PC_W, INSTR_W);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               last_br;
  logic               ds_pending;

  logic               full;
  logic               empty;
  logic               redirect_drop;
  logic               push;
  logic               pop;
  logic               f_is_branch;
  fq_tag_t            f_tag;
  logic [ENTRY_W-1:0] head;
  fq_tag_t            head_tag;

  instr_predecode u_predecode (
    .instr     (f_instr[31:0]),
    .is_branch (f_is_branch)
  );

  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign f_ready       = !full;
  assign d_valid       = !empty;
  assign redirect_drop = redirect_flush & d_valid;
  assign push          = f_valid & f_ready & !exp_flush & !redirect_drop;
  assign pop           = d_accept & d_valid;

  assign f_tag = '{is_branch:    f_is_branch,
                   inst_invalid: f_inst_invalid,
                   inst_illegal: f_inst_illegal,
                   inst_miss:    f_inst_miss};

  assign head     = mem[rd_ptr];
  assign head_tag = fq_tag_t'(head[ENTRY_W-1 -: $bits(fq_tag_t)]);

  assign d_pc           = d_valid ? head[PC_W-1:0]         : '0;
  assign d_instr        = d_valid ? head[PC_W +: INSTR_W]  : '0;
  assign d_inst_miss    = d_valid & head_tag.inst_miss;
  assign d_inst_illegal = d_valid & head_tag.inst_illegal;
  assign d_inst_invalid = d_valid & head_tag.inst_invalid;
  assign d_in_delayslot = d_valid & last_br;
  assign q_count        = count;

  // Entry storage: written on accepted pushes only
  always_ff @(posedge Clk) begin
    // NOTE: storage has no reset; pointers/count alone define which entries are live.
    if (push) mem[wr_ptr] <= {f_tag, f_instr, f_pc};
  end

  // Pointer, occupancy and delay-slot state; Clr > exp_flush > redirect > push/pop
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every branch sees pre-edge state.
    if (Clr) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_br    <= 1'b0;
      ds_pending <= 1'b0;
    end else if (exp_flush) begin
      rd_ptr     <= wr_ptr;
      count      <= '0;
      last_br    <= 1'b0;
      ds_pending <= 1'b0;
    end else if (redirect_drop) begin
      // Head is the delay-slot candidate: keep it (or pop it) and drop the rest
      wr_ptr <= rd_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        count   <= '0;
        last_br <= head_tag.is_branch;
      end else begin
        count   <= CNT_W'(1);
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        last_br <= head_tag.is_branch;
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      // Empty-queue redirect: the delay slot has not arrived yet
      if (push)                ds_pending <= 1'b0;
      else if (redirect_flush) ds_pending <= 1'b1;
    end
  end

endmodule
